// File: rtl/rx_frame_stager_pkg.sv
// Shared constants and helpers for the receive frame stager.
package rx_frame_stager_pkg;

  localparam int unsigned DWORD_BYTES = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_CMD   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_STS   = 3'd4;

  function automatic logic [2:0] popcount4(input logic [3:0] keep);
    popcount4 = 3'(keep[0]) + 3'(keep[1]) + 3'(keep[2]) + 3'(keep[3]);
  endfunction

endpackage

// File: rtl/rx_frame_stager_frame_fifo.sv
// Synchronous frame FIFO with first-word-fall-through output register.
// rd_en gates prefetch into the output register; clear flushes everything.
module rx_frame_stager_frame_fifo #(
  parameter int unsigned AW = 9,
  parameter int unsigned W  = 36
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  output logic          rd_last,
  output logic          empty,
  output logic [AW:0]   word_count
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   mem_count;
  logic [AW:0]   mem_count_n;
  logic          wr_ok;
  logic          load;
  logic          rd_valid_n;

  // Refill the output register whenever it is empty or being consumed.
  always_comb begin
    wr_ok       = wr_en && (mem_count != (AW+1)'(DEPTH));
    load        = rd_en && (mem_count != '0) && (!rd_valid || pop);
    mem_count_n = mem_count + (AW+1)'(wr_ok) - (AW+1)'(load);
    rd_valid_n  = load || (rd_valid && !pop);
  end

  always_ff @(posedge aclk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_count  <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      empty      <= 1'b1;
      word_count <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_count  <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      empty      <= 1'b1;
      word_count <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (load) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      mem_count  <= mem_count_n;
      rd_valid   <= rd_valid_n;
      rd_last    <= rd_valid_n && (mem_count_n == '0);
      empty      <= !rd_valid_n && (mem_count_n == '0);
      word_count <= mem_count_n + (AW+1)'(rd_valid_n);
    end
  end

endmodule

// File: rtl/rx_frame_stager.sv
// Stages one received frame in a local FIFO, then issues a write-DMA command,
// replays the frame and reports per-frame status.
module rx_frame_stager
  import rx_frame_stager_pkg::*;
#(
  parameter int unsigned ADDRESS_BITS = 32,
  parameter int unsigned LENGTH_BITS  = 32,
  parameter int unsigned FIFO_AW      = 9
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDRESS_BITS-1:0] buf_address,
  input  logic [LENGTH_BITS-1:0]  buf_size,
  input  logic                    buf_valid,
  output logic                    buf_ready,
  input  logic [31:0]             s_tdata,
  input  logic [3:0]              s_tkeep,
  input  logic                    s_tlast,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [ADDRESS_BITS-1:0] cmd_address,
  output logic [LENGTH_BITS-1:0]  cmd_bytes,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [31:0]             m_tdata,
  output logic [3:0]              m_tkeep,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [LENGTH_BITS-1:0]  sts_bytes,
  output logic                    sts_trunc,
  output logic                    sts_valid,
  input  logic                    sts_ready
);

  localparam int unsigned KEEP_W     = 4;
  localparam int unsigned FIFO_W     = 32 + KEEP_W;
  localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;
  localparam logic [LENGTH_BITS-1:0] FIFO_BYTES = LENGTH_BITS'(DWORD_BYTES * FIFO_DEPTH);
  localparam logic [FIFO_AW:0]       FIFO_WORDS = (FIFO_AW+1)'(FIFO_DEPTH);

  logic [2:0]             state;
  logic [2:0]             state_n;
  logic [LENGTH_BITS-1:0] limit_q;
  logic [LENGTH_BITS-1:0] fill_q;
  logic [LENGTH_BITS-1:0] fill_n;
  logic [LENGTH_BITS-1:0] beat_bytes;
  logic                   trunc_q;
  logic                   trunc_n;
  logic                   s_beat;
  logic                   beat_fits;
  logic                   fifo_wr;
  logic                   fifo_clear;
  logic                   fifo_rd_en;
  logic                   fifo_empty;
  logic [FIFO_AW:0]       fifo_words;
  logic [FIFO_W-1:0]      fifo_rd_data;

  assign cmd_bytes = fill_q;
  assign sts_bytes = fill_q;
  assign sts_trunc = trunc_q;
  assign m_tdata   = fifo_rd_data[FIFO_W-1:KEEP_W];
  assign m_tkeep   = fifo_rd_data[KEEP_W-1:0];

  // Next state, byte accounting and FIFO control.
  always_comb begin
    state_n    = state;
    fill_n     = fill_q;
    trunc_n    = trunc_q;
    fifo_wr    = 1'b0;
    fifo_clear = 1'b0;
    fifo_rd_en = (state == S_DRAIN);
    s_beat     = s_tvalid && s_tready;
    beat_bytes = LENGTH_BITS'(popcount4(s_tkeep));
    // Word-count guard keeps runs of sparse-keep beats from overrunning the FIFO.
    beat_fits  = !trunc_q && ((fill_q + beat_bytes) <= limit_q) && (fifo_words < FIFO_WORDS);
    case (state)
      S_IDLE: begin
        if (buf_valid && buf_ready) state_n = S_FILL;
      end
      S_FILL: begin
        if (s_beat) begin
          if (beat_fits) begin
            fifo_wr = 1'b1;
            fill_n  = fill_q + beat_bytes;
          end else begin
            trunc_n = 1'b1;
          end
          if (s_tlast) state_n = (fill_n != '0) ? S_CMD : S_STS;
        end
      end
      S_CMD: begin
        if (cmd_valid && cmd_ready) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if ((m_tvalid && m_tready && m_tlast) || fifo_empty) state_n = S_STS;
      end
      S_STS: begin
        if (sts_valid && sts_ready) begin
          state_n    = S_IDLE;
          fill_n     = '0;
          trunc_n    = 1'b0;
          fifo_clear = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next-state decode.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= S_IDLE;
      fill_q      <= '0;
      trunc_q     <= 1'b0;
      limit_q     <= '0;
      cmd_address <= '0;
      buf_ready   <= 1'b0;
      s_tready    <= 1'b0;
      cmd_valid   <= 1'b0;
      sts_valid   <= 1'b0;
    end else begin
      state   <= state_n;
      fill_q  <= fill_n;
      trunc_q <= trunc_n;
      if ((state == S_IDLE) && buf_valid && buf_ready) begin
        cmd_address <= buf_address;
        limit_q     <= (buf_size < FIFO_BYTES) ? buf_size : FIFO_BYTES;
      end
      buf_ready <= (state_n == S_IDLE);
      s_tready  <= (state_n == S_FILL);
      cmd_valid <= (state_n == S_CMD);
      sts_valid <= (state_n == S_STS);
    end
  end

  rx_frame_stager_frame_fifo #(
    .AW (FIFO_AW),
    .W  (FIFO_W)
  ) u_fifo (
    .aclk       (aclk),
    .areset     (areset),
    .clear      (fifo_clear),
    .wr_en      (fifo_wr),
    .wr_data    ({s_tdata, s_tkeep}),
    .rd_en      (fifo_rd_en),
    .pop        (m_tready),
    .rd_data    (fifo_rd_data),
    .rd_valid   (m_tvalid),
    .rd_last    (m_tlast),
    .empty      (fifo_empty),
    .word_count (fifo_words)
  );

endmodule
